// File: rtl/iq_pkg.sv
// Shared definitions for the IQ FIFO read-side sequencer: state encoding,
// default widths and the minimum sample period.
package iq_pkg;

  localparam int RATE_W_DEF      = 16;
  localparam int LEVEL_W_DEF     = 13;
  localparam int START_LEVEL_DEF = 256;
  localparam int MIN_RATE        = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RD_I  = 3'd2,
    S_LAT_I = 3'd3,
    S_RD_Q  = 3'd4,
    S_LAT_Q = 3'd5,
    S_READY = 3'd6
  } iq_state_t;

  // Streaming states are the ones that own the tick counter.
  function automatic logic is_streaming(iq_state_t s);
    return (s != S_IDLE) && (s != S_FILL);
  endfunction

endpackage

// File: rtl/iq_rate_tick.sv
// Sample-period tick generator: counts while run is high and pulses tick when
// the count reaches max(rate_div, MIN_RATE), then wraps to zero.
module iq_rate_tick
  import iq_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [RATE_W-1:0] rate_div,
  output logic              tick
);

  logic [RATE_W-1:0] count_reg;
  logic [RATE_W-1:0] count_next;
  logic [RATE_W-1:0] limit;

  assign limit = (rate_div < RATE_W'(MIN_RATE)) ? RATE_W'(MIN_RATE) : rate_div;
  assign tick  = run && (count_reg == limit);

  // A limit lowered below the live count lets the counter roll over naturally.
  always_comb begin
    count_next = count_reg + 1'b1;
    if (!run || tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/iq_fifo_scheduler.sv
// Read-side sequencer for the IQ sample FIFO: fetches I then Q bytes, stages
// the pair and presents it on each rate tick, handling priming and underflow.
module iq_fifo_scheduler
  import iq_pkg::*;
#(
  parameter int RATE_W      = RATE_W_DEF,
  parameter int LEVEL_W     = LEVEL_W_DEF,
  parameter int START_LEVEL = START_LEVEL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [RATE_W-1:0]  rate_div,
  input  logic [7:0]         fifo_q,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_used,
  output logic               fifo_rd,
  output logic [7:0]         iq_i,
  output logic [7:0]         iq_q,
  output logic               iq_valid,
  output logic               running,
  output logic               underflow,
  output logic [7:0]         underflow_cnt
);

  iq_state_t  state_reg, state_next;
  logic       running_reg, running_next;
  logic [7:0] iq_i_reg, iq_i_next;
  logic [7:0] iq_q_reg, iq_q_next;
  logic       iq_valid_reg, iq_valid_next;
  logic       underflow_reg, underflow_next;
  logic [7:0] underflow_cnt_reg, underflow_cnt_next;
  logic [7:0] stage_i_reg, stage_i_next;
  logic [7:0] stage_q_reg, stage_q_next;
  logic       staged_reg, staged_next;
  logic       tick;

  iq_rate_tick #(
    .RATE_W(RATE_W)
  ) u_rate_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (running_reg),
    .rate_div(rate_div),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      running_reg       <= 1'b0;
      iq_i_reg          <= 8'd0;
      iq_q_reg          <= 8'd0;
      iq_valid_reg      <= 1'b0;
      underflow_reg     <= 1'b0;
      underflow_cnt_reg <= 8'd0;
      stage_i_reg       <= 8'd0;
      stage_q_reg       <= 8'd0;
      staged_reg        <= 1'b0;
    end else begin
      state_reg         <= state_next;
      running_reg       <= running_next;
      iq_i_reg          <= iq_i_next;
      iq_q_reg          <= iq_q_next;
      iq_valid_reg      <= iq_valid_next;
      underflow_reg     <= underflow_next;
      underflow_cnt_reg <= underflow_cnt_next;
      stage_i_reg       <= stage_i_next;
      stage_q_reg       <= stage_q_next;
      staged_reg        <= staged_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    running_next       = running_reg;
    iq_i_next          = iq_i_reg;
    iq_q_next          = iq_q_reg;
    iq_valid_next      = 1'b0;
    underflow_next     = 1'b0;
    underflow_cnt_next = underflow_cnt_reg;
    stage_i_next       = stage_i_reg;
    stage_q_next       = stage_q_reg;
    staged_next        = staged_reg;
    fifo_rd            = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (fifo_used >= LEVEL_W'(START_LEVEL)) begin
          state_next   = S_RD_I;
          running_next = 1'b1;
        end
      end
      S_RD_I: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          state_next = S_LAT_I;
        end
      end
      S_LAT_I: begin
        stage_i_next = fifo_q;
        state_next   = S_RD_Q;
      end
      // enable is deliberately not looked at until the Q byte is in hand.
      S_RD_Q: begin
        if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          state_next = S_LAT_Q;
        end
      end
      S_LAT_Q: begin
        stage_q_next = fifo_q;
        staged_next  = 1'b1;
        state_next   = S_READY;
      end
      S_READY: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (tick && staged_reg) begin
          iq_i_next     = stage_i_reg;
          iq_q_next     = stage_q_reg;
          iq_valid_next = 1'b1;
          staged_next   = 1'b0;
          state_next    = S_RD_I;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (state_next == S_IDLE) begin
      running_next  = 1'b0;
      iq_i_next     = 8'd0;
      iq_q_next     = 8'd0;
      iq_valid_next = 1'b0;
      staged_next   = 1'b0;
    end else if (tick && is_streaming(state_reg) && !(state_reg == S_READY && staged_reg)) begin
      // Missed deadline: emit a zero sample but keep any half-fetched pair.
      iq_i_next      = 8'd0;
      iq_q_next      = 8'd0;
      iq_valid_next  = 1'b1;
      underflow_next = 1'b1;
      if (underflow_cnt_reg != 8'hFF) begin
        underflow_cnt_next = underflow_cnt_reg + 8'd1;
      end
      if (state_reg == S_RD_I && fifo_empty) begin
        state_next   = S_FILL;
        running_next = 1'b0;
      end
    end
  end

  assign iq_i          = iq_i_reg;
  assign iq_q          = iq_q_reg;
  assign iq_valid      = iq_valid_reg;
  assign running       = running_reg;
  assign underflow     = underflow_reg;
  assign underflow_cnt = underflow_cnt_reg;

endmodule

// File: tb/tb_iq_fifo_scheduler.sv
// Bench for iq_fifo_scheduler: a queue-based FIFO with registered flags feeds
// the DUT; samples are checked against I/Q pairing and timing rules.
module tb_iq_fifo_scheduler;

  localparam int RATE_W  = 16;
  localparam int LEVEL_W = 13;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [RATE_W-1:0]  rate_div = 16'd9;
  logic [7:0]         fifo_q = 8'd0;
  logic               fifo_empty = 1'b1;
  logic [LEVEL_W-1:0] fifo_used = '0;
  logic               fifo_rd;
  logic [7:0]         iq_i;
  logic [7:0]         iq_q;
  logic               iq_valid;
  logic               running;
  logic               underflow;
  logic [7:0]         underflow_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'd0;
  logic       flush = 1'b0;
  logic [7:0] seq_byte = 8'd1;
  logic [7:0] mem[$];

  int  b2b_cnt = 0;
  int  rd_empty_cnt = 0;
  int  bad_sample_cnt = 0;
  logic prev_rd = 1'b0;

  iq_fifo_scheduler #(
    .RATE_W(RATE_W),
    .LEVEL_W(LEVEL_W),
    .START_LEVEL(256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rate_div     (rate_div),
    .fifo_q       (fifo_q),
    .fifo_empty   (fifo_empty),
    .fifo_used    (fifo_used),
    .fifo_rd      (fifo_rd),
    .iq_i         (iq_i),
    .iq_q         (iq_q),
    .iq_valid     (iq_valid),
    .running      (running),
    .underflow    (underflow),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: 1-cycle read latency, flags registered after push/pop.
  always @(posedge clk) begin
    if (flush) begin
      mem.delete();
    end else begin
      if (fifo_rd && mem.size() > 0) fifo_q <= mem.pop_front();
      if (push_en) mem.push_back(push_data);
    end
    fifo_used  <= LEVEL_W'(mem.size());
    fifo_empty <= (mem.size() == 0);
  end

  // Rule watcher: read strobe spacing and the shape of every presented sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd && prev_rd) b2b_cnt++;
      if (fifo_rd && fifo_empty) rd_empty_cnt++;
      if (underflow && !iq_valid) bad_sample_cnt++;
      if (iq_valid && underflow && (iq_i != 8'd0 || iq_q != 8'd0)) bad_sample_cnt++;
      if (iq_valid && !underflow && (iq_i[0] != 1'b1 || iq_q != iq_i + 8'd1)) bad_sample_cnt++;
    end
    prev_rd = fifo_rd;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_one(input logic [7:0] b);
    push_en = 1'b1;
    push_data = b;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic push_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      push_one(seq_byte);
      seq_byte = seq_byte + 8'd1;
    end
  endtask

  task automatic wait_running(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (running) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic next_sample(input int limit, output bit ok, output int gap);
    ok = 1'b0;
    gap = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      gap++;
      if (iq_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    push_en = 1'b0;
    rst = 1'b1;
    flush = 1'b1;
    step(3);
    flush = 1'b0;
    rst = 1'b0;
    seq_byte = 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; flush = 1'b1; rate_div = 16'd9;
    step(3);
    vectors++;
    if ({fifo_rd, iq_valid, running, underflow} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {fifo_rd, iq_valid, running, underflow});
    end
    vectors++;
    if ({iq_i, iq_q} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_iq: got %04h want 0000", {iq_i, iq_q});
    end
    vectors++;
    if (underflow_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d want 0", underflow_cnt);
    end
    rst = 1'b0; enable = 1'b0; flush = 1'b0;
    step(5);
    vectors++;
    if ({fifo_rd, running} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_hold: got %b want 00", {fifo_rd, running});
    end
    $display("reset: flags=%b iq=%02h/%02h cnt=%0d", {fifo_rd, iq_valid, running, underflow}, iq_i, iq_q, underflow_cnt);
  endtask

  task automatic test_stream();
    bit ok;
    int gap;
    logic [7:0] ei;
    do_reset();
    rate_div = 16'd9;
    enable = 1'b1;
    push_bytes(255);
    step(2);
    vectors++;
    if (running !== 1'b0) begin
      miscompares++;
      $display("FAIL prime_early: running=%b want 0 at 255 bytes", running);
    end
    push_bytes(1);
    wait_running(20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL prime_start: running=%b want 1", running);
    end
    ei = 8'd1;
    for (int s = 0; s < 6; s++) begin
      next_sample(40, ok, gap);
      $display("stream sample %0d: i=%02h q=%02h gap=%0d uf=%b", s, iq_i, iq_q, gap, underflow);
      vectors++;
      if (!ok || gap != 10 || underflow !== 1'b0 || iq_i !== ei || iq_q !== ei + 8'd1) begin
        miscompares++;
        $display("FAIL stream_sample%0d: got i=%02h q=%02h gap=%0d uf=%b want i=%02h q=%02h gap=10 uf=0",
                 s, iq_i, iq_q, gap, underflow, ei, ei + 8'd1);
      end
      ei = ei + 8'd2;
    end
    enable = 1'b0;
    step(12);
    vectors++;
    if ({running, iq_i, iq_q} !== 17'd0) begin
      miscompares++;
      $display("FAIL stream_stop: running=%b i=%02h q=%02h want 0/00/00", running, iq_i, iq_q);
    end
  endtask

  task automatic test_min_rate();
    bit ok;
    int gap;
    logic [7:0] prev_i;
    rate_div = 16'd2;
    enable = 1'b1;
    for (int n = 0; n < 300 && fifo_used < 13'd256; n++) begin
      push_one(seq_byte);
      seq_byte = seq_byte + 8'd1;
    end
    wait_running(20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL minrate_start: running=%b want 1", running);
    end
    prev_i = 8'd0;
    for (int s = 0; s < 10; s++) begin
      next_sample(40, ok, gap);
      $display("minrate sample %0d: i=%02h q=%02h gap=%0d uf=%b", s, iq_i, iq_q, gap, underflow);
      vectors++;
      if (!ok || gap != 5 || underflow !== 1'b0 || (s > 0 && iq_i !== prev_i + 8'd2)) begin
        miscompares++;
        $display("FAIL minrate_sample%0d: got i=%02h gap=%0d uf=%b want i=%02h gap=5 uf=0",
                 s, iq_i, gap, underflow, prev_i + 8'd2);
      end
      prev_i = iq_i;
    end
    enable = 1'b0;
    step(12);
    vectors++;
    if (b2b_cnt + rd_empty_cnt + bad_sample_cnt !== 0) begin
      miscompares++;
      $display("FAIL minrate_rules: b2b=%0d rd_empty=%0d bad=%0d want 0", b2b_cnt, rd_empty_cnt, bad_sample_cnt);
    end
  endtask

  task automatic test_underflow_boundary();
    bit ok;
    int gap, good, rds, vals;
    logic [7:0] li, lq, first;
    do_reset();
    rate_div = 16'd4;
    enable = 1'b1;
    push_bytes(256);
    good = 0; li = 8'd0; lq = 8'd0;
    for (int s = 0; s < 200; s++) begin
      next_sample(60, ok, gap);
      if (!ok || underflow) break;
      good++; li = iq_i; lq = iq_q;
    end
    $display("boundary: good=%0d last=%02h/%02h uf=%b cnt=%0d running=%b", good, li, lq, underflow, underflow_cnt, running);
    vectors++;
    if (!ok || good != 128 || li !== 8'hFF || lq !== 8'h00) begin
      miscompares++;
      $display("FAIL boundary_drain: got good=%0d last=%02h/%02h want 128 FF/00", good, li, lq);
    end
    vectors++;
    if ({underflow, running, underflow_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL boundary_uf: got uf=%b run=%b cnt=%0d want 1/0/1", underflow, running, underflow_cnt);
    end
    rds = 0; vals = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_rd) rds++;
      if (iq_valid) vals++;
    end
    vectors++;
    if (rds != 0 || vals != 0 || running !== 1'b0 || underflow_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL boundary_fill: rds=%0d valids=%0d run=%b cnt=%0d want 0/0/0/1", rds, vals, running, underflow_cnt);
    end
    first = seq_byte;
    push_bytes(256);
    wait_running(20, ok);
    next_sample(40, ok, gap);
    $display("boundary resume: i=%02h q=%02h uf=%b", iq_i, iq_q, underflow);
    vectors++;
    if (!ok || iq_i !== first || iq_q !== first + 8'd1 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL boundary_resume: got i=%02h q=%02h want %02h/%02h", iq_i, iq_q, first, first + 8'd1);
    end
  endtask

  task automatic test_mid_pair();
    bit ok;
    int gap, good;
    do_reset();
    rate_div = 16'd4;
    enable = 1'b1;
    push_bytes(256);
    push_one(8'h7F);
    good = 0;
    for (int s = 0; s < 200; s++) begin
      next_sample(60, ok, gap);
      if (!ok || underflow) break;
      good++;
    end
    $display("midpair: good=%0d uf=%b cnt=%0d running=%b", good, underflow, underflow_cnt, running);
    vectors++;
    if (!ok || good != 128 || underflow !== 1'b1 || running !== 1'b1 || underflow_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL midpair_starve: got good=%0d uf=%b run=%b cnt=%0d want 128/1/1/1", good, underflow, running, underflow_cnt);
    end
    push_one(8'h80);
    next_sample(20, ok, gap);
    $display("midpair resume: i=%02h q=%02h uf=%b", iq_i, iq_q, underflow);
    vectors++;
    if (!ok || iq_i !== 8'h7F || iq_q !== 8'h80 || underflow !== 1'b0 || underflow_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL midpair_align: got i=%02h q=%02h uf=%b cnt=%0d want 7F/80/0/1", iq_i, iq_q, underflow, underflow_cnt);
    end
  endtask

  task automatic test_enable_rd_q();
    bit ok, found;
    int gap, rds, vals;
    do_reset();
    rate_div = 16'd9;
    enable = 1'b1;
    push_bytes(256);
    next_sample(400, ok, gap);
    vectors++;
    if (!ok || iq_i !== 8'h01 || iq_q !== 8'h02) begin
      miscompares++;
      $display("FAIL endis_first: got i=%02h q=%02h want 01/02", iq_i, iq_q);
    end
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_rd) begin
        found = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    rds = 0; vals = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_rd) rds++;
      if (iq_valid) vals++;
    end
    $display("endis: q_rd_seen=%b later_rds=%0d valids=%0d running=%b", found, rds, vals, running);
    vectors++;
    if (!found || rds != 0 || vals != 0 || {running, iq_i, iq_q} !== 17'd0) begin
      miscompares++;
      $display("FAIL endis_stop: q_rd=%b rds=%0d valids=%0d run=%b i=%02h q=%02h want 1/0/0/0/00/00",
               found, rds, vals, running, iq_i, iq_q);
    end
    enable = 1'b1;
    push_bytes(8);
    next_sample(100, ok, gap);
    $display("endis resume: i=%02h q=%02h uf=%b", iq_i, iq_q, underflow);
    vectors++;
    if (!ok || iq_i !== 8'h05 || iq_q !== 8'h06 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL endis_resume: got i=%02h q=%02h want 05/06", iq_i, iq_q);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int gap, uf;
    logic [7:0] exp_cnt;
    do_reset();
    rate_div = 16'd4;
    enable = 1'b1;
    push_bytes(257);
    uf = 0;
    for (int s = 0; s < 700 && uf < 300; s++) begin
      next_sample(60, ok, gap);
      if (!ok) begin
        vectors++;
        miscompares++;
        $display("FAIL saturate_timeout: no iq_valid after sample %0d", s);
        break;
      end
      if (underflow) begin
        uf++;
        exp_cnt = (uf > 255) ? 8'd255 : 8'(uf);
        vectors++;
        if (underflow_cnt !== exp_cnt) begin
          miscompares++;
          $display("FAIL saturate_cnt%0d: got %0d want %0d", uf, underflow_cnt, exp_cnt);
        end
        if (uf % 50 == 0) $display("saturate: underflows=%0d cnt=%0d", uf, underflow_cnt);
      end
    end
    vectors++;
    if (uf != 300 || underflow_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate_final: got uf=%0d cnt=%0d want 300/255", uf, underflow_cnt);
    end
    push_one(seq_byte);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (fifo_rd) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("midfetch reset: rd_seen=%b flags=%b iq=%02h/%02h cnt=%0d", ok, {fifo_rd, iq_valid, running, underflow}, iq_i, iq_q, underflow_cnt);
    vectors++;
    if (!ok || {fifo_rd, iq_valid, running, underflow, iq_i, iq_q, underflow_cnt} !== 28'd0) begin
      miscompares++;
      $display("FAIL midfetch_reset: rd_seen=%b flags=%b iq=%02h/%02h cnt=%0d want 1/0000/00/00/0",
               ok, {fifo_rd, iq_valid, running, underflow}, iq_i, iq_q, underflow_cnt);
    end
    do_reset();
    vectors++;
    if (b2b_cnt + rd_empty_cnt + bad_sample_cnt !== 0) begin
      miscompares++;
      $display("FAIL global_rules: b2b=%0d rd_empty=%0d bad=%0d want 0", b2b_cnt, rd_empty_cnt, bad_sample_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_min_rate();
    test_underflow_boundary();
    test_mid_pair();
    test_enable_rd_q();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
